// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_adder_pkg;

   localparam int unsigned WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// One-bit combinational full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell stepped LSB first over WIDTH bits.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               busy_q, done_q;
   logic               fa_sum, fa_cout;
   logic               last_bit;
`ifdef SERIAL_ADDER_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   full_adder u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = 1'b0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
            carry_d = fa_cout;
            if (last_bit) begin
               state_d = DONE;
               cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
               // Carry into the MSB is the carry register on this final step
               ovf_d   = carry_q ^ fa_cout;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule : serial_adder_ctrl

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add controller that sequences a single `full_adder` cell over two WIDTH-bit operands, one bit per clock, LSB first. It owns the carry flip-flop, operand shift registers, bit counter and result register, and presents a start/done handshake to the surrounding datapath. It is the sequential wrapper that turns the 1-bit `full_adder` into a multi-bit adder at minimal area.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request an add; sampled on rising edge of `clk`.
- `a`  input  WIDTH  operand A; sampled only on the accepting edge.
- `b`  input  WIDTH  operand B; sampled only on the accepting edge.
- `cin`  input  1  carry-in; sampled only on the accepting edge.
- `busy`  output  1  high while bits are being processed (state RUN).
- `done`  output  1  one-cycle pulse; `sum`/`cout` valid.
- `sum`  output  WIDTH  result; held until the next accepted `start`.
- `cout`  output  1  carry out of bit WIDTH-1; held like `sum`.
- `ovf`  output  1  signed overflow; present only with `SERIAL_ADDER_OVF_EN`.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE/DONE + `start`=1: latch `a`, `b` into shift registers; carry reg <= `cin`; counter <= 0; `sum` <= 0; `cout` <= 0; go to RUN. `start`=0: IDLE stays IDLE, DONE goes to IDLE.
- RUN, each edge: `full_adder` inputs are a_sh[0], b_sh[0], carry reg. `sum` shifts right with the adder sum bit entering bit WIDTH-1; a_sh/b_sh shift right (zero fill); carry reg <= adder cout; counter++.
- RUN, edge with counter == WIDTH-1: last bit processed as above; `cout` <= adder cout; go to DONE.
- `start` while in RUN: ignored, no effect on the operation in progress.
- Counter width `$clog2(WIDTH)`; never wraps, because RUN exits at WIDTH-1.
- `done` = (state == DONE); `busy` = (state == RUN).
- `rst_n` low at any time, including mid-RUN: immediate return to IDLE, operation abandoned, all registers cleared.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
- Accepting edge E0. Bits processed on E1..E_WIDTH. `done`=1 in the cycle after E_WIDTH, for exactly one cycle.
- Latency from accepting edge to `done` high: WIDTH edges. Back-to-back throughput: one add per WIDTH+1 cycles, achieved when `start` is held or re-asserted during DONE.
- `sum`/`cout`/`ovf` hold their final values from DONE until the next accepting edge, at which they clear to 0. During RUN, `sum` holds partial bits and must not be consumed.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined: adds the `ovf` port and a 1-bit register. On the final RUN edge, `ovf` <= carry into bit WIDTH-1 (the carry reg value) XOR adder cout. `ovf` clears on the accepting edge and on reset.
- `SERIAL_ADDER_OVF_EN` undefined: no `ovf` port and no associated logic; all other behaviour is identical.

## Structure
- Shared package `serial_adder_pkg`: state enum type (IDLE=2'd0, RUN=2'd1, DONE=2'd2), `WIDTH_MAX`=32.
- Exactly one sub-module: the existing `full_adder` (ports a, b, cin, sum, cout), instantiated once. It is purely combinational; all state lives in `serial_adder_ctrl`.

## Test plan
- WIDTH=8, a=8'h3C, b=8'h5A, cin=0, one-cycle `start` -> `busy` high for 8 cycles; `done` pulses 8 edges after the accepting edge; `sum`=8'h96, `cout`=0.
- a=8'hFF, b=8'h01, cin=0 -> `sum`=8'h00, `cout`=1, `ovf`=0. Then a=8'hFF, b=8'hFF, cin=1 -> `sum`=8'hFF, `cout`=1.
- With `SERIAL_ADDER_OVF_EN`: a=8'h7F, b=8'h01, cin=0 -> `sum`=8'h80, `cout`=0, `ovf`=1. Then a=8'h80, b=8'h80 -> `sum`=8'h00, `cout`=1, `ovf`=1.
- `start` pulsed with new operands at RUN cycle 3 -> ignored; result matches the original operands; only one `done` pulse.
- `rst_n` low at RUN cycle 4 -> all outputs 0 at once, state IDLE, no `done`. A fresh `start` after release completes normally.
- `start` held high continuously with a=8'h01, b=8'h02 -> `done` every 9 cycles, `sum`=8'h03 each time, `sum` reads 0 on the cycle after each `done`.
